// File: rtl/minirv_mc_ctrl.sv
// minirv_mc_ctrl: multi-cycle IF/ID/EX/MEM/WB control FSM for the miniRV datapath.
// Optional build macro MINIRV_MEM_WAIT_EN: IF and MEM stall until mem_rdy_i is high.
`timescale 1ns/1ps
module minirv_mc_ctrl #(
    parameter int CNT_W           = 32,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [31:0]      inst_i,
    input  logic             br_i,
    input  logic             mem_rdy_i,
    output logic             irom_re_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       npc_op_o,
    output logic [2:0]       sext_op_o,
    output logic [3:0]       alu_op_o,
    output logic             alub_sel_o,
    output logic             rf_we_o,
    output logic [1:0]       wd_sel_o,
    output logic             dram_re_o,
    output logic             dram_we_o,
    output logic [2:0]       state_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retire_o
);
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic             is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_ill;
    logic             rdy, last_ex, unused_ok;
    logic [3:0]       alu_rr;

    assign opc     = inst_i[6:0];
    assign f3      = inst_i[14:12];
    assign is_r    = opc == 7'b0110011;
    assign is_i    = opc == 7'b0010011;
    assign is_ld   = opc == 7'b0000011;
    assign is_st   = opc == 7'b0100011;
    assign is_br   = opc == 7'b1100011;
    assign is_jal  = opc == 7'b1101111;
    assign is_jalr = opc == 7'b1100111;
    assign is_lui  = opc == 7'b0110111;
    assign is_ill  = !(is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui);
    // Branches and (when not halting) illegal opcodes finish in EX.
    assign last_ex = is_br | is_ill;
    assign unused_ok = ^{inst_i[31], inst_i[29:15], inst_i[11:7], mem_rdy_i};

`ifdef MINIRV_MEM_WAIT_EN
    assign rdy = mem_rdy_i;
`else
    assign rdy = 1'b1;
`endif

    // ALU op for register/immediate arithmetic; bit 30 selects SUB only for R-type.
    always_comb begin
        case (f3)
            3'd0:    alu_rr = (is_r && inst_i[30]) ? 4'd1 : 4'd0;
            3'd1:    alu_rr = 4'd5;
            3'd2:    alu_rr = 4'd8;
            3'd3:    alu_rr = 4'd9;
            3'd4:    alu_rr = 4'd4;
            3'd5:    alu_rr = inst_i[30] ? 4'd7 : 4'd6;
            3'd6:    alu_rr = 4'd3;
            default: alu_rr = 4'd2;
        endcase
    end

    // Next state and per-state enables; selects are driven only once IR holds the instruction.
    always_comb begin
        state_d    = state_q;
        irom_re_o  = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        npc_op_o   = 2'd0;
        sext_op_o  = 3'd0;
        alu_op_o   = 4'd0;
        alub_sel_o = 1'b0;
        rf_we_o    = 1'b0;
        wd_sel_o   = 2'd0;
        dram_re_o  = 1'b0;
        dram_we_o  = 1'b0;
        if (state_q != S_IF && state_q != S_HALT) begin
            sext_op_o  = is_st ? 3'd1 : is_br ? 3'd2 : is_lui ? 3'd3 : is_jal ? 3'd4 : 3'd0;
            alu_op_o   = (is_r || is_i) ? alu_rr : is_br ? 4'd1 : 4'd0;
            alub_sel_o = !(is_r || is_br);
            wd_sel_o   = is_ld ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
            npc_op_o   = is_br ? {1'b0, br_i} : is_jal ? 2'd2 : is_jalr ? 2'd3 : 2'd0;
        end
        case (state_q)
            S_IF: begin
                irom_re_o = rst_n;
                ir_we_o   = rst_n & rdy;
                state_d   = rdy ? S_ID : S_IF;
            end
            S_ID:  state_d = (is_ill && HALT_ON_ILLEGAL) ? S_HALT : S_EX;
            S_EX: begin
                pc_we_o = last_ex;
                state_d = last_ex ? S_IF : (is_ld || is_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dram_re_o = is_ld;
                dram_we_o = is_st;
                pc_we_o   = is_st & rdy;
                state_d   = !rdy ? S_MEM : is_st ? S_IF : S_WB;
            end
            S_WB: begin
                rf_we_o = 1'b1;
                pc_we_o = 1'b1;
                state_d = S_IF;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign illegal_d = illegal_q | (state_q == S_ID && is_ill);
    assign retire_d  = retire_q + {{(CNT_W-1){1'b0}}, pc_we_o};

    // State register, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retire_q  <= retire_d;
        end
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign retire_o  = retire_q;
endmodule

// File: tb/tb_minirv_mc_ctrl.sv
// tb_minirv_mc_ctrl: directed bench for minirv_mc_ctrl with a per-instruction stage model.
`timescale 1ns/1ps
module tb_minirv_mc_ctrl;
    localparam int CW = 4;
`ifdef MINIRV_MEM_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif
    localparam logic [31:0] ALU_F3 = 32'h23649850;

    logic          clk_i = 1'b0, rst_n = 1'b0, br_i = 1'b0, mem_rdy_i = 1'b0;
    logic [31:0]   inst_i = 32'h0;
    logic          irom_re_o, ir_we_o, pc_we_o, alub_sel_o, rf_we_o, dram_re_o, dram_we_o, illegal_o;
    logic [1:0]    npc_op_o, wd_sel_o;
    logic [2:0]    sext_op_o, state_o;
    logic [3:0]    alu_op_o;
    logic [CW-1:0] retire_o;

    minirv_mc_ctrl #(.CNT_W(CW), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .inst_i(inst_i), .br_i(br_i), .mem_rdy_i(mem_rdy_i),
        .irom_re_o(irom_re_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .npc_op_o(npc_op_o),
        .sext_op_o(sext_op_o), .alu_op_o(alu_op_o), .alub_sel_o(alub_sel_o), .rf_we_o(rf_we_o),
        .wd_sel_o(wd_sel_o), .dram_re_o(dram_re_o), .dram_we_o(dram_we_o), .state_o(state_o),
        .illegal_o(illegal_o), .retire_o(retire_o)
    );

    // Rising edges at 7,17,...: reset release at 500 lands mid-cycle, before the 507 edge.
    initial begin
        #2;
        forever #5 clk_i = ~clk_i;
    end

    typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_LUI, C_ILL} cls_t;
    typedef struct {
        int st, irom, irw, pcw, rfw, dre, dwe, npc, wd, alu, alub, sext, ill, ret;
    } exp_t;

    exp_t        e;
    bit          chk_on = 1'b0;
    int          n_vec = 0, n_err = 0;
    int          m_ret = 0, m_ill = 0;
    int          seen_cyc, seen_pc, seen_rf, seen_dre, seen_dwe;
    logic [31:0] seq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, want);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic int alu_of(input logic [31:0] ins, input cls_t c);
        logic [31:0] tab = ALU_F3;
        logic [2:0]  f3  = ins[14:12];
        if (c == C_BR) return 1;
        if (c == C_LD || c == C_ST || c == C_JALR) return 0;
        if (c != C_R && c != C_I) return -1;
        if (f3 == 3'd0 && c == C_R && ins[30]) return 1;
        if (f3 == 3'd5 && ins[30]) return 7;
        return int'(tab[f3*4 +: 4]);
    endfunction

    function automatic int sext_of(input cls_t c);
        return c == C_ST ? 1 : c == C_BR ? 2 : c == C_LUI ? 3 : c == C_JAL ? 4 : c == C_R ? -1 : 0;
    endfunction

    function automatic int wd_of(input cls_t c);
        return c == C_LD ? 1 : (c == C_JAL || c == C_JALR) ? 2 : c == C_LUI ? 3 : 0;
    endfunction

    function automatic int npc_of(input cls_t c, input logic br);
        return c == C_BR ? int'(br) : c == C_JAL ? 2 : c == C_JALR ? 3 : 0;
    endfunction

    // Single compare point: every enabled cycle, DUT outputs against the model record.
    always @(negedge clk_i) if (chk_on) begin
        chk("state", state_o, e.st);
        chk("irom_re", irom_re_o, e.irom);
        chk("ir_we", ir_we_o, e.irw);
        chk("pc_we", pc_we_o, e.pcw);
        chk("rf_we", rf_we_o, e.rfw);
        chk("dram_re", dram_re_o, e.dre);
        chk("dram_we", dram_we_o, e.dwe);
        chk("retire", retire_o, e.ret);
        if (e.ill >= 0) chk("illegal", illegal_o, e.ill);
        if (e.npc >= 0) chk("npc_op", npc_op_o, e.npc);
        if (e.wd >= 0) chk("wd_sel", wd_sel_o, e.wd);
        if (e.alu >= 0) chk("alu_op", alu_op_o, e.alu);
        if (e.alub >= 0) chk("alub_sel", alub_sel_o, e.alub);
        if (e.sext >= 0) chk("sext_op", sext_op_o, e.sext);
        seen_cyc++;
        seen_pc  += int'(pc_we_o);
        seen_rf  += int'(rf_we_o);
        seen_dre += int'(dram_re_o);
        seen_dwe += int'(dram_we_o);
        seq = {seq[27:0], 1'b0, state_o};
    end

    task automatic rst_checks(input string tag);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_irom"}, irom_re_o, 0);
        chk({tag, "_irw"}, ir_we_o, 0);
        chk({tag, "_pcw"}, pc_we_o, 0);
        chk({tag, "_rfw"}, rf_we_o, 0);
        chk({tag, "_dram"}, {dram_re_o, dram_we_o}, 0);
        chk({tag, "_retire"}, retire_o, 0);
        chk({tag, "_illegal"}, illegal_o, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_checks("areset");
        @(posedge clk_i); #1;
        rst_n = 1'b1;
        m_ret = 0;
        m_ill = 0;
    endtask

    // Walk one instruction through its stage path; called just after a rising edge with DUT in IF.
    task automatic run(input logic [31:0] ins, input logic br, input int if_st, input int mem_st, input int abort_c);
        cls_t c = classify(ins);
        int   stg[$];
        int   cyc = 0;
        case (c)
            C_LD:    stg = '{0, 1, 2, 3, 4};
            C_ST:    stg = '{0, 1, 2, 3};
            C_BR:    stg = '{0, 1, 2};
            C_ILL:   stg = '{0, 1};
            default: stg = '{0, 1, 2, 4};
        endcase
        inst_i = ins;
        br_i = br;
        seen_cyc = 0; seen_pc = 0; seen_rf = 0; seen_dre = 0; seen_dwe = 0; seq = 0;
        for (int k = 0; k < stg.size(); k++) begin
            int st   = stg[k];
            int reps = !WAIT ? 0 : st == 0 ? if_st : st == 3 ? mem_st : 0;
            for (int r = 0; r <= reps; r++) begin
                bit rdy = (r == reps);
                bit fin = (k == stg.size() - 1) && c != C_ILL && rdy;
                mem_rdy_i = WAIT ? rdy : 1'b0;
                e.st   = st;
                e.irom = int'(st == 0);
                e.irw  = int'(st == 0 && rdy);
                e.pcw  = int'(fin);
                e.rfw  = int'(st == 4);
                e.dre  = int'(st == 3 && c == C_LD);
                e.dwe  = int'(st == 3 && c == C_ST);
                e.npc  = fin ? npc_of(c, br) : -1;
                e.wd   = st == 4 ? wd_of(c) : -1;
                e.alu  = st == 2 ? alu_of(ins, c) : -1;
                e.alub = st == 2 ? int'(!(c == C_R || c == C_BR)) : -1;
                e.sext = st == 2 ? sext_of(c) : -1;
                e.ill  = (st == 1 && c == C_ILL) ? -1 : m_ill;
                e.ret  = m_ret;
                if (cyc == abort_c) begin
                    #2;
                    chk_on = 1'b0;
                    do_reset();
                    return;
                end
                chk_on = 1'b1;
                @(posedge clk_i); #1;
                if (fin) m_ret = (m_ret + 1) % (1 << CW);
                if (st == 1 && c == C_ILL) m_ill = 1;
                cyc++;
            end
        end
        if (c == C_ILL) begin
            for (int h = 0; h < 4; h++) begin
                e.st = 7; e.irom = 0; e.irw = 0; e.pcw = 0; e.rfw = 0; e.dre = 0; e.dwe = 0;
                e.npc = -1; e.wd = -1; e.alu = -1; e.alub = -1; e.sext = -1;
                e.ill = 1; e.ret = m_ret;
                @(posedge clk_i); #1;
            end
        end
        chk_on = 1'b0;
    endtask

    initial begin
        #100;
        rst_checks("reset");
        chk("reset_sel", {npc_op_o, sext_op_o, alu_op_o, alub_sel_o, wd_sel_o}, 0);
        #400;
        rst_n = 1'b1;
        run(32'h002081B3, 1'b0, 0, 0, -1);
        chk("add_seq", seq, 32'h0124);
        chk("add_rf", seen_rf, 1);
        chk("add_pc", seen_pc, 1);
        run(32'h00402283, 1'b0, 0, 0, -1);
        chk("lw_seq", seq, 32'h01234);
        chk("lw_dre", seen_dre, 1);
        chk("lw_rf", seen_rf, 1);
        run(32'h00208463, 1'b1, 0, 0, -1);
        chk("beq_t_seq", seq, 32'h012);
        chk("beq_t_rf", seen_rf, 0);
        run(32'h00208463, 1'b0, 0, 0, -1);
        chk("beq_n_cyc", seen_cyc, 3);
        chk("beq_n_pc", seen_pc, 1);
        run(32'h402081B3, 1'b0, 0, 0, -1);
        run(32'h4020D1B3, 1'b0, 0, 0, -1);
        run(32'h0020B1B3, 1'b0, 0, 0, -1);
        run(32'h0020F1B3, 1'b0, 2, 0, -1);
        chk("and_irw_cyc", seen_cyc, WAIT ? 6 : 4);
        run(32'h40008193, 1'b0, 0, 0, -1);
        run(32'h4010D193, 1'b0, 0, 0, -1);
        run(32'h0010D193, 1'b0, 0, 0, -1);
        run(32'h0020A193, 1'b0, 0, 0, -1);
        run(32'h0040C193, 1'b0, 0, 0, -1);
        run(32'h0060E193, 1'b0, 0, 0, -1);
        run(32'h00109193, 1'b0, 0, 0, -1);
        run(32'h0020A423, 1'b0, 0, 3, -1);
        chk("sw_dwe", seen_dwe, WAIT ? 4 : 1);
        chk("sw_pc", seen_pc, 1);
        run(32'h00209463, 1'b1, 0, 0, -1);
        run(32'h008000EF, 1'b0, 0, 0, -1);
        run(32'h000100E7, 1'b0, 0, 0, -1);
        run(32'h123450B7, 1'b0, 0, 0, -1);
        chk("wrap_retire", retire_o, 4);
        run(32'h00402283, 1'b0, 0, 0, 2);
`ifdef MINIRV_MEM_WAIT_EN
        run(32'h0020A423, 1'b0, 0, 3, 4);
`endif
        run(32'h002081B3, 1'b0, 0, 0, -1);
        run(32'h00000097, 1'b0, 0, 0, -1);
        chk("auipc_seq", seq, 32'h017777);
        chk("auipc_pc", seen_pc, 0);
        chk("auipc_retire", retire_o, 1);
        chk("auipc_illegal", illegal_o, 1);
        do_reset();
        run(32'hFFFFFFFF, 1'b0, 0, 0, -1);
        chk("ones_state", state_o, 7);
        chk("ones_pc", seen_pc, 0);
        chk("ones_retire", retire_o, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
